// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] CHOOSE_OFF = 4'b1111;

  // Entry n is the glyph for hex digit n (lowercase b and d).
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_en;
  } shadow_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Lookup into the shared glyph table.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with
// anti-ghost blanking, decimal points and leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp,
  input  logic        lz_en,
  output logic [3:0]  bcd_choose,
  output logic [7:0]  bcd_display
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_div
    $error("seg_scan_driver: SCAN_DIV out of range");
  end

  if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYC must be below SCAN_DIV");
  end

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  shadow_t       sh;
  scan_state_e   mode;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [15:0]   upper;
  logic          lz_blank;

  // Digit select, leading-zero test and scan phase from current state.
  always_comb begin
    nibble = sh.value[{idx, 2'b00} +: 4];
    upper = sh.value >> {idx, 2'b00};
    lz_blank = sh.lz_en && (idx != '0) && (upper == 16'h0);
    mode = (32'(cnt) < 32'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
  end

  hex_to_seg u_dec (
    .nibble(nibble),
    .glyph (glyph)
  );

  // Shadow registers: capture on load, ignored during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= '{value: value, dp: dp, lz_en: lz_en};
    end
  end

  // Slot counter, digit index and registered segment outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      bcd_choose <= CHOOSE_OFF;
      bcd_display <= SEG_OFF;
    end else begin
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      unique case (mode)
        ST_BLANK: begin
          bcd_choose <= CHOOSE_OFF;
          bcd_display <= SEG_OFF;
        end
        ST_SHOW: begin
          bcd_choose <= ~(4'b0001 << idx);
          bcd_display <= {~sh.dp[idx], lz_blank ? 7'h7F : glyph};
        end
        default: begin
          bcd_choose <= CHOOSE_OFF;
          bcd_display <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, BLANK_CYC=1).
// Cycle model predicts outputs; a queue carries them to the checker.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        lz_en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  bcd_choose;
  logic [7:0]  bcd_display;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV (4),
    .BLANK_CYC(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .dp         (dp),
    .lz_en      (lz_en),
    .bcd_choose (bcd_choose),
    .bcd_display(bcd_display)
  );

  typedef struct packed {
    logic [3:0] choose;
    logic [7:0] disp;
  } out_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][7:0] digits;
  } vec_t;

  localparam logic [3:0][7:0] ZERO_DIG = {4{8'hC0}};

  out_t            sb[$];
  int              n_checks = 0;
  int              n_fail = 0;
  int              m_cnt = 0;
  int              m_idx = 0;
  logic [3:0][7:0] m_dig;
  logic [3:0][7:0] pend_dig;
  string           phase = "init";
  vec_t            vecs[8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s t=%0t actual=%h required=%h",
               phase, name, $time, act, exp);
    end
  endtask

  task automatic tick();
    out_t e;
    logic [3:0] ch;
    ch = 4'b0001 << m_idx;
    if (reset || m_cnt < 1) e = '{choose: 4'hF, disp: 8'hFF};
    else e = '{choose: ~ch, disp: m_dig[m_idx]};
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_cnt = 0;
      m_idx = 0;
      m_dig = ZERO_DIG;
    end else begin
      if (load) m_dig = pend_dig;
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    #1;
    e = sb.pop_front();
    check("choose", 32'(bcd_choose), 32'(e.choose));
    check("display", 32'(bcd_display), 32'(e.disp));
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic load_vec(vec_t v);
    value = v.value;
    dp = v.dp;
    lz_en = v.lz;
    pend_dig = v.digits;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_slot(int i, int c);
    int guard = 0;
    while (!(m_idx == i && m_cnt == c) && guard < 32) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 32) begin
      n_fail++;
      $display("FAIL %s/wait_slot timeout idx=%0d cnt=%0d required idx=%0d cnt=%0d",
               phase, m_idx, m_cnt, i, c);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    load = 1'b0;
    lz_en = 1'b0;
    value = 16'h0;
    dp = 4'h0;
    pend_dig = ZERO_DIG;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h000A, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h88}};
    vecs[2] = '{16'hBEEF, 4'b0100, 1'b0, {8'h83, 8'h06, 8'h86, 8'h8E}};
    vecs[3] = '{16'h0000, 4'b1010, 1'b1, {8'h7F, 8'hFF, 8'h7F, 8'hC0}};
    vecs[4] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[5] = '{16'h8C0D, 4'b0000, 1'b1, {8'h80, 8'hC6, 8'hC0, 8'hA1}};
    vecs[6] = '{16'h5678, 4'b0000, 1'b0, {8'h92, 8'h82, 8'hF8, 8'h80}};
    vecs[7] = '{16'h9A0C, 4'b1111, 1'b0, {8'h10, 8'h08, 8'h40, 8'h46}};

    phase = "reset";
    value = 16'h1234;
    pend_dig = vecs[0].digits;
    load = 1'b1;
    do_reset(2);
    load = 1'b0;
    repeat (8) tick();

    for (int k = 0; k < 8; k++) begin
      phase = $sformatf("vec%0d", k);
      do_reset(1);
      load_vec(vecs[k]);
      repeat (16) tick();
    end

    phase = "midload";
    do_reset(1);
    load_vec(vecs[0]);
    wait_slot(1, 2);
    v = '{16'hFFFF, 4'b0000, 1'b0, {4{8'h8E}}};
    load_vec(v);
    repeat (12) tick();

    phase = "loadheld";
    for (int k = 1; k < 6; k++) begin
      v = '{16'(k), 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      case (k)
        1: v.digits[0] = 8'hF9;
        2: v.digits[0] = 8'hA4;
        3: v.digits[0] = 8'hB0;
        4: v.digits[0] = 8'h99;
        default: v.digits[0] = 8'h92;
      endcase
      value = v.value;
      dp = v.dp;
      lz_en = v.lz;
      pend_dig = v.digits;
      load = 1'b1;
      tick();
    end
    load = 1'b0;
    repeat (8) tick();

    phase = "rst_dig2";
    do_reset(1);
    load_vec(vecs[0]);
    wait_slot(2, 2);
    do_reset(1);
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
